// File: rtl/counter_sequencer_pkg.sv
// Shared state encoding, default width and small helpers for the counter sequencer.
package counter_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/counter_sequencer_count_unit.sv
// Counter plus companion toggle bit, steered by clear/increment/wrap/hold controls.
module count_unit
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             wrap,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             toggle
);

    // inc marks a counting edge (toggle flips); wrap/hold only choose what count does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            toggle <= 1'b0;
        end else if (clr) begin
            count  <= '0;
            toggle <= 1'b0;
        end else begin
            if (inc) begin
                toggle <= ~toggle;
            end
            if (wrap) begin
                count <= '0;
            end else if (inc && !hold) begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/pause timer around count_unit: FSM, latched limit/reload and done pulse.
module counter_sequencer
    import counter_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             toggle,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] limit_q;
    logic             reload_q;
    logic             clr;
    logic             inc;
    logic             wrap;
    logic             hold;
    logic             latch;
    logic             done_d;
    logic             terminal;

    assign terminal = (count == limit_q);
    assign state    = state_q;

    count_unit #(
        .WIDTH (WIDTH)
    ) u_count_unit (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .inc    (inc),
        .wrap   (wrap),
        .hold   (hold),
        .count  (count),
        .toggle (toggle)
    );

    // Terminal is checked before incrementing, so count never passes the latched limit.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        inc     = 1'b0;
        wrap    = 1'b0;
        hold    = 1'b0;
        latch   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (!stop && !pause && start) begin
                    latch   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else if (pause) begin
                    hold    = 1'b1;
                    state_d = ST_PAUSE;
                end else if (terminal) begin
                    inc    = 1'b1;
                    done_d = 1'b1;
                    if (reload_q) begin
                        wrap = 1'b1;
                    end else begin
                        hold    = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    inc = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hold = 1'b1;
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (stop) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end else if (!pause && start) begin
                    latch   = 1'b1;
                    wrap    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    hold = 1'b1;
                end
            end
            default: begin
                clr     = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            limit_q  <= '0;
            reload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= is_busy(state_d);
            done    <= done_d;
            if (latch) begin
                limit_q  <= limit;
                reload_q <= auto_reload;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed scoreboard bench: stimulus pushes expected post-edge outputs, a monitor pops and compares.
module tb_counter_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef struct packed {
        logic [9:0] count;
        logic       toggle;
        logic       busy;
        logic       done;
        logic [1:0] state;
    } obs_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [9:0] limit;
    logic [9:0] count;
    logic       toggle;
    logic       busy;
    logic       done;
    logic [1:0] state;

    obs_t  exp_q[$];
    string name_q[$];
    int    tests_run;
    int    tests_failed;

    counter_sequencer #(
        .WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .limit       (limit),
        .count       (count),
        .toggle      (toggle),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o = {count, toggle, busy, done, state};
        return o;
    endfunction

    task automatic check_output(input string nm, input obs_t act, input obs_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got count=%0d toggle=%0b busy=%0b done=%0b state=%0d, expected count=%0d toggle=%0b busy=%0b done=%0b state=%0d",
                     nm, act.count, act.toggle, act.busy, act.done, act.state,
                     exp.count, exp.toggle, exp.busy, exp.done, exp.state);
        end
    endtask

    // Each queued entry describes the outputs just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            check_output(name_q.pop_front(), observe(), exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_cycle(input string nm, input logic [9:0] c, input logic t,
                                input logic b, input logic d, input logic [1:0] s);
        obs_t e;
        e = {c, t, b, d, s};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic apply_stimulus(input logic st, input logic sp, input logic ps,
                                  input logic ar, input logic [9:0] lim);
        start       = st;
        stop        = sp;
        pause       = ps;
        auto_reload = ar;
        limit       = lim;
    endtask

    task automatic go_idle(input string nm);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, limit);
        expect_cycle(nm, 10'd0, 1'b0, 1'b0, 1'b0, S_IDLE);
        tick();
        stop = 1'b0;
        expect_cycle({nm, "_hold"}, 10'd0, 1'b0, 1'b0, 1'b0, S_IDLE);
    endtask

    task automatic start_run(input string nm, input logic ar, input logic [9:0] lim);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, ar, lim);
        expect_cycle(nm, 10'd0, 1'b0, 1'b1, 1'b0, S_RUN);
    endtask

    task automatic test_one_shot();
        start_run("oneshot_start", 1'b0, 10'd5);
        for (int k = 1; k <= 5; k++) begin
            tick();
            start = 1'b0;
            expect_cycle("oneshot_count", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        expect_cycle("oneshot_terminal", 10'd5, 1'b0, 1'b0, 1'b1, S_DONE);
        tick();
        expect_cycle("oneshot_done_drop", 10'd5, 1'b0, 1'b0, 1'b0, S_DONE);
        tick();
        expect_cycle("oneshot_done_hold", 10'd5, 1'b0, 1'b0, 1'b0, S_DONE);
        go_idle("oneshot_stop");
    endtask

    task automatic test_auto_reload();
        start_run("reload_start", 1'b1, 10'd3);
        for (int n = 1; n <= 20; n++) begin
            tick();
            start = 1'b0;
            expect_cycle("reload_seq", 10'(n % 4), n[0], 1'b1, (n % 4) == 0, S_RUN);
        end
        go_idle("reload_stop");
    endtask

    task automatic test_pause();
        start_run("pause_start", 1'b0, 10'd10);
        for (int k = 1; k <= 4; k++) begin
            tick();
            start = 1'b0;
            expect_cycle("pause_pre", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        for (int p = 0; p < 4; p++) begin
            tick();
            pause = 1'b1;
            expect_cycle("pause_frozen", 10'd4, 1'b0, 1'b1, 1'b0, S_PAUSE);
        end
        tick();
        pause = 1'b0;
        expect_cycle("pause_resume", 10'd4, 1'b0, 1'b1, 1'b0, S_RUN);
        for (int k = 5; k <= 10; k++) begin
            tick();
            expect_cycle("pause_post", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        expect_cycle("pause_terminal", 10'd10, 1'b1, 1'b0, 1'b1, S_DONE);
        tick();
        expect_cycle("pause_done_drop", 10'd10, 1'b1, 1'b0, 1'b0, S_DONE);
        go_idle("pause_stop");
    endtask

    task automatic test_priority();
        start_run("latch_start", 1'b0, 10'd8);
        tick();
        start = 1'b0;
        expect_cycle("latch_count", 10'd1, 1'b1, 1'b1, 1'b0, S_RUN);
        for (int k = 2; k <= 8; k++) begin
            tick();
            limit       = 10'd2;
            auto_reload = 1'b1;
            expect_cycle("latch_ignore", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        expect_cycle("latch_terminal", 10'd8, 1'b1, 1'b0, 1'b1, S_DONE);
        go_idle("latch_stop");
        start_run("prio_start", 1'b0, 10'd8);
        for (int k = 1; k <= 3; k++) begin
            tick();
            start = 1'b0;
            expect_cycle("prio_count", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'd8);
        expect_cycle("prio_stop_wins", 10'd0, 1'b0, 1'b0, 1'b0, S_IDLE);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd8);
        expect_cycle("prio_idle", 10'd0, 1'b0, 1'b0, 1'b0, S_IDLE);
    endtask

    task automatic test_edges();
        start_run("lim0_start", 1'b0, 10'd0);
        tick();
        start = 1'b0;
        expect_cycle("lim0_terminal", 10'd0, 1'b1, 1'b0, 1'b1, S_DONE);
        tick();
        expect_cycle("lim0_done_drop", 10'd0, 1'b1, 1'b0, 1'b0, S_DONE);
        go_idle("lim0_stop");
        start_run("lim0r_start", 1'b1, 10'd0);
        for (int n = 1; n <= 3; n++) begin
            tick();
            start = 1'b0;
            expect_cycle("lim0r_pulse", 10'd0, n[0], 1'b1, 1'b1, S_RUN);
        end
        go_idle("lim0r_stop");
        start_run("max_start", 1'b0, 10'd1023);
        for (int k = 1; k <= 1023; k++) begin
            tick();
            start = 1'b0;
            expect_cycle("max_count", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        expect_cycle("max_terminal", 10'd1023, 1'b0, 1'b0, 1'b1, S_DONE);
        tick();
        expect_cycle("max_no_wrap", 10'd1023, 1'b0, 1'b0, 1'b0, S_DONE);
        go_idle("max_stop");
    endtask

    task automatic test_reset_mid_run();
        obs_t zero;
        zero = '0;
        start_run("rst_start", 1'b1, 10'd100);
        for (int k = 1; k <= 37; k++) begin
            tick();
            start = 1'b0;
            expect_cycle("rst_pre", 10'(k), k[0], 1'b1, 1'b0, S_RUN);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async", observe(), zero);
        tick();
        check_output("rst_held", observe(), zero);
        rst_n = 1'b1;
        tick();
        expect_cycle("rst_after", 10'd0, 1'b0, 1'b0, 1'b0, S_IDLE);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        repeat (2) tick();
        check_output("reset_state", observe(), obs_t'(0));
        rst_n = 1'b1;
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_priority();
        test_edges();
        test_reset_mid_run();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
